// File: rtl/imem_boot_arbiter.sv
// Single-port instruction memory arbiter: boot loader writes, then fetch reads
// every cycle, with debug reads stealing one cycle at a time behind a stall.
module imem_boot_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              reload,
  input  logic [31:0]       fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_stall,
  output logic              core_rst,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    LOAD,
    RUN,
    DBG,
    DBG_RESP,
    GAP
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   wr_ptr;
  logic                last_slot;
  logic                xfer;
  logic                unused_fetch_hi;

  // The PC is a full 32-bit word address; imem only decodes the low bits.
  assign unused_fetch_hi = ^fetch_addr[31:ADDR_W];

  assign last_slot   = (wr_ptr == {ADDR_W{1'b1}});
  assign xfer        = (state == LOAD) && ld_valid;
  assign mem_wdata   = ld_data;
  assign fetch_instr = mem_rdata;
  assign dbg_rdata   = dbg_ack ? mem_rdata : '0;

  always_comb begin
    state_next  = state;
    ld_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = fetch_addr[ADDR_W-1:0];
    fetch_stall = 1'b0;
    dbg_ack     = 1'b0;
    case (state)
      LOAD: begin
        ld_ready    = 1'b1;
        fetch_stall = 1'b1;
        mem_addr    = wr_ptr;
        mem_we      = ld_valid;
        if (ld_valid && (ld_last || last_slot)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (reload) begin
          state_next = LOAD;
        end else if (dbg_req) begin
          state_next = DBG;
        end
      end
      DBG: begin
        mem_addr    = dbg_addr;
        fetch_stall = 1'b1;
        state_next  = DBG_RESP;
      end
      DBG_RESP: begin
        // mem_rdata carries the debug word this cycle, so decode must not take it
        fetch_stall = 1'b1;
        dbg_ack     = 1'b1;
        state_next  = GAP;
      end
      GAP: begin
        state_next = RUN;
      end
      default: begin
        fetch_stall = 1'b1;
        state_next  = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Pipeline reset follows the state we are about to be in, so it drops the
  // cycle after the final load word and rises the cycle after a reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst <= 1'b1;
    end else begin
      core_rst <= (state_next == LOAD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      load_count <= '0;
      load_ovf   <= 1'b0;
    end else if (xfer) begin
      wr_ptr     <= wr_ptr + PTR_ONE;
      load_count <= {1'b0, wr_ptr} + COUNT_ONE;
      if (!ld_last && last_slot) begin
        load_ovf <= 1'b1;
      end
    end else if ((state == RUN) && reload) begin
      wr_ptr     <= '0;
      load_count <= '0;
    end
  end

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Bench for imem_boot_arbiter: a behavioural imem plus write/debug scoreboards,
// and a small ADDR_W=2 instance for the overflow path.
module tb_imem_boot_arbiter;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;
  localparam int SMALL_W = 2;

  logic              clk;
  logic              rst;
  logic              ld_valid, ld_ready, ld_last, reload;
  logic [DATA_W-1:0] ld_data;
  logic [31:0]       fetch_addr;
  logic [DATA_W-1:0] fetch_instr;
  logic              fetch_stall, core_rst;
  logic              dbg_req, dbg_ack;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W:0]   load_count;
  logic              load_ovf;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we;

  logic               ld_valid_s, ld_ready_s, ld_last_s, reload_s;
  logic [DATA_W-1:0]  ld_data_s;
  logic [31:0]        fetch_addr_s;
  logic [DATA_W-1:0]  unused_fetch_instr_s, unused_dbg_rdata_s;
  logic               fetch_stall_s, core_rst_s, dbg_req_s, unused_dbg_ack_s;
  logic [SMALL_W-1:0] dbg_addr_s, mem_addr_s;
  logic [SMALL_W:0]   load_count_s;
  logic               load_ovf_s, mem_we_s;
  logic [DATA_W-1:0]  mem_wdata_s, mem_rdata_s;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W+DATA_W-1:0] wr_q[$];
  logic [DATA_W-1:0]        dbg_q[$];
  logic [ADDR_W+DATA_W-1:0] exp_wr;
  logic [DATA_W-1:0]        exp_dbg;
  logic [DATA_W-1:0]        imem [1024];

  imem_boot_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .reload(reload), .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
    .fetch_stall(fetch_stall), .core_rst(core_rst), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .load_count(load_count), .load_ovf(load_ovf),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  imem_boot_arbiter #(.ADDR_W(SMALL_W), .DATA_W(DATA_W)) dut2 (
    .clk(clk), .rst(rst), .ld_valid(ld_valid_s), .ld_ready(ld_ready_s), .ld_data(ld_data_s),
    .ld_last(ld_last_s), .reload(reload_s), .fetch_addr(fetch_addr_s),
    .fetch_instr(unused_fetch_instr_s), .fetch_stall(fetch_stall_s), .core_rst(core_rst_s),
    .dbg_req(dbg_req_s), .dbg_addr(dbg_addr_s), .dbg_ack(unused_dbg_ack_s),
    .dbg_rdata(unused_dbg_rdata_s), .load_count(load_count_s), .load_ovf(load_ovf_s),
    .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_we(mem_we_s), .mem_rdata(mem_rdata_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read, read-first imem model
  always @(posedge clk) begin
    if (mem_we) imem[mem_addr] <= mem_wdata;
    mem_rdata <= imem[mem_addr];
  end

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      checks++;
      if (ld_valid !== 1'b1) begin errors++; $display("[TB] FAIL we_without_valid got ld_valid=%b want 1", ld_valid); end
      checks++;
      if (wr_q.size() == 0) begin
        errors++; $display("[TB] FAIL unexpected_write got addr=%0h data=%0h want none", mem_addr, mem_wdata);
      end else begin
        exp_wr = wr_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_wr) begin
          errors++; $display("[TB] FAIL mem_write got %0h/%0h want %0h/%0h", mem_addr, mem_wdata,
                             exp_wr[ADDR_W+DATA_W-1:DATA_W], exp_wr[DATA_W-1:0]);
        end
      end
    end
    if (!rst && dbg_ack) begin
      checks++;
      if (dbg_q.size() == 0) begin
        errors++; $display("[TB] FAIL unexpected_dbg_ack got rdata=%0h want no ack", dbg_rdata);
      end else begin
        exp_dbg = dbg_q.pop_front();
        if (dbg_rdata !== exp_dbg) begin
          errors++; $display("[TB] FAIL dbg_rdata got %0h want %0h", dbg_rdata, exp_dbg);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (core_rst !== 1'b1) begin errors++; $display("[TB] FAIL rst_core_rst got %b want 1", core_rst); end
    checks++; if (fetch_stall !== 1'b1) begin errors++; $display("[TB] FAIL rst_fetch_stall got %b want 1", fetch_stall); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ld_ready got %b want 1", ld_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_we got %b want 0", mem_we); end
    checks++; if (dbg_ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_dbg_ack got %b want 0", dbg_ack); end
    checks++; if (load_count !== '0) begin errors++; $display("[TB] FAIL rst_load_count got %0d want 0", load_count); end
    checks++; if (load_ovf !== 1'b0) begin errors++; $display("[TB] FAIL rst_load_ovf got %b want 0", load_ovf); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_load_basic();
    logic [DATA_W-1:0] words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
      wr_q.push_back({ADDR_W'(i), words[i]});
      @(negedge clk);
      checks++; if (core_rst !== 1'b1) begin errors++; $display("[TB] FAIL load_core_rst got %b want 1", core_rst); end
      next_cycle();
    end
    ld_valid = 1'b0; ld_last = 1'b0; fetch_addr = 32'd0;
    @(negedge clk);
    checks++; if (core_rst !== 1'b0) begin errors++; $display("[TB] FAIL load_end_core_rst got %b want 0", core_rst); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("[TB] FAIL load_end_stall got %b want 0", fetch_stall); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL load_end_ld_ready got %b want 0", ld_ready); end
    checks++; if (load_count !== 11'd4) begin errors++; $display("[TB] FAIL load_count got %0d want 4", load_count); end
    checks++; if (load_ovf !== 1'b0) begin errors++; $display("[TB] FAIL load_ovf got %b want 0", load_ovf); end
    next_cycle();
    @(negedge clk);
    checks++; if (fetch_instr !== 32'h11) begin errors++; $display("[TB] FAIL first_fetch got %0h want 11", fetch_instr); end
    next_cycle();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      ld_valid_s = 1'b1; ld_data_s = 32'hC0 + 32'(i); ld_last_s = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_we_s !== 1'b1 || mem_addr_s !== SMALL_W'(i) || mem_wdata_s !== 32'hC0 + 32'(i)) begin
        errors++; $display("[TB] FAIL ovf_write got we=%b addr=%0d data=%0h want 1/%0d/%0h", mem_we_s, mem_addr_s, mem_wdata_s, i, 32'hC0 + 32'(i));
      end
      next_cycle();
    end
    ld_valid_s = 1'b0;
    @(negedge clk);
    checks++; if (core_rst_s !== 1'b0 || fetch_stall_s !== 1'b0) begin errors++; $display("[TB] FAIL ovf_run got core_rst=%b stall=%b want 0/0", core_rst_s, fetch_stall_s); end
    checks++; if (load_ovf_s !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b want 1", load_ovf_s); end
    checks++; if (load_count_s !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count got %0d want 4", load_count_s); end
    checks++; if (dut2.wr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL ovf_wr_ptr got %0d want 0", dut2.wr_ptr); end
    reload_s = 1'b1;
    next_cycle();
    reload_s = 1'b0;
    @(negedge clk);
    checks++; if (ld_ready_s !== 1'b1 || core_rst_s !== 1'b1) begin errors++; $display("[TB] FAIL ovf_reload got ready=%b core_rst=%b want 1/1", ld_ready_s, core_rst_s); end
    checks++; if (load_ovf_s !== 1'b1 || load_count_s !== 3'd0) begin errors++; $display("[TB] FAIL ovf_sticky got ovf=%b count=%0d want 1/0", load_ovf_s, load_count_s); end
    next_cycle();
    ld_valid_s = 1'b1; ld_last_s = 1'b1; ld_data_s = 32'hD0;
    @(negedge clk);
    checks++; if (mem_addr_s !== 2'd0) begin errors++; $display("[TB] FAIL ovf_restart_addr got %0d want 0", mem_addr_s); end
    next_cycle();
    ld_valid_s = 1'b0; ld_last_s = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rst_s !== 1'b0 || load_ovf_s !== 1'b1 || load_count_s !== 3'd1) begin
      errors++; $display("[TB] FAIL ovf_second_load got core_rst=%b ovf=%b count=%0d want 0/1/1", core_rst_s, load_ovf_s, load_count_s);
    end
    next_cycle();
  endtask

  task automatic test_toggle();
    int w;
    logic v;
    reload = 1'b1;
    next_cycle();
    reload = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      v = (k % 2 == 0);
      w = k / 2;
      ld_valid = v; ld_last = v && (w == 5);
      ld_data = v ? 32'h11 * 32'(w + 1) : 32'hDEAD_BEEF;
      if (v) wr_q.push_back({ADDR_W'(w), 32'h11 * 32'(w + 1)});
      @(negedge clk);
      if (k == 0) begin
        checks++; if (core_rst !== 1'b1 || load_count !== '0) begin errors++; $display("[TB] FAIL reload_entry got core_rst=%b count=%0d want 1/0", core_rst, load_count); end
      end
      checks++; if (mem_we !== v) begin errors++; $display("[TB] FAIL toggle_we k=%0d got %b want %b", k, mem_we, v); end
      next_cycle();
    end
    ld_valid = 1'b1; ld_last = 1'b0; ld_data = 32'hBAD0;
    @(negedge clk);
    checks++; if (core_rst !== 1'b0) begin errors++; $display("[TB] FAIL toggle_end_core_rst got %b want 0", core_rst); end
    checks++; if (load_count !== 11'd6) begin errors++; $display("[TB] FAIL toggle_count got %0d want 6", load_count); end
    checks++; if (mem_we !== 1'b0 || ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL valid_in_run got we=%b ready=%b want 0/0", mem_we, ld_ready); end
    next_cycle();
    ld_valid = 1'b0;
  endtask

  task automatic test_dbg();
    logic exp_stall;
    fetch_addr = 32'd5; dbg_addr = 10'd2; dbg_req = 1'b1;
    dbg_q.push_back(32'h33);
    for (int c = 0; c < 6; c++) begin
      exp_stall = (c == 1) || (c == 2);
      @(negedge clk);
      checks++; if (fetch_stall !== exp_stall) begin errors++; $display("[TB] FAIL dbg_stall c=%0d got %b want %b", c, fetch_stall, exp_stall); end
      checks++; if (dbg_ack !== (c == 2)) begin errors++; $display("[TB] FAIL dbg_ack c=%0d got %b want %b", c, dbg_ack, c == 2); end
      if (c == 1) begin
        checks++; if (mem_addr !== 10'd2) begin errors++; $display("[TB] FAIL dbg_mem_addr got %0d want 2", mem_addr); end
      end
      if (c == 4) begin
        checks++; if (fetch_instr !== 32'h66) begin errors++; $display("[TB] FAIL dbg_after_gap_instr got %0h want 66", fetch_instr); end
      end
      next_cycle();
      if (c == 0) dbg_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ack, exp_stall;
    int run_len = 0;
    int max_run = 0;
    dbg_addr = 10'd1; dbg_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      exp_ack   = (k % 4 == 2);
      exp_stall = (k % 4 == 1) || (k % 4 == 2);
      if (exp_ack) dbg_q.push_back(32'h22);
      @(negedge clk);
      checks++; if (dbg_ack !== exp_ack) begin errors++; $display("[TB] FAIL b2b_ack k=%0d got %b want %b", k, dbg_ack, exp_ack); end
      checks++; if (fetch_stall !== exp_stall) begin errors++; $display("[TB] FAIL b2b_stall k=%0d got %b want %b", k, fetch_stall, exp_stall); end
      run_len = (fetch_stall === 1'b1) ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      next_cycle();
    end
    dbg_req = 1'b0;
    checks++; if (max_run > 2) begin errors++; $display("[TB] FAIL b2b_stall_run got %0d want <=2", max_run); end
  endtask

  task automatic test_reload_dbg();
    logic [DATA_W-1:0] words [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    logic got = 1'b0;
    int lat = -1;
    reload = 1'b1; dbg_req = 1'b1; dbg_addr = 10'd3;
    dbg_q.push_back(32'hA4);
    next_cycle();
    reload = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
      wr_q.push_back({ADDR_W'(i), words[i]});
      @(negedge clk);
      checks++; if (core_rst !== 1'b1 || ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL rd_load_state i=%0d got core_rst=%b ready=%b want 1/1", i, core_rst, ld_ready); end
      checks++; if (dbg_ack !== 1'b0) begin errors++; $display("[TB] FAIL rd_early_ack i=%0d got %b want 0", i, dbg_ack); end
      next_cycle();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (dbg_ack === 1'b1) begin got = 1'b1; lat = c; end
      else next_cycle();
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL rd_ack_timeout got none want ack"); end
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL rd_ack_latency got %0d want 2", lat); end
    next_cycle();
    dbg_req = 1'b0;
  endtask

  task automatic test_rst_midload();
    next_cycle();
    reload = 1'b1;
    next_cycle();
    reload = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_last = 1'b0; ld_data = 32'hB1 + 32'(i);
      wr_q.push_back({ADDR_W'(i), 32'hB1 + 32'(i)});
      @(negedge clk);
      next_cycle();
    end
    ld_valid = 1'b0;
    checks++; if (load_count !== 11'd2) begin errors++; $display("[TB] FAIL partial_count got %0d want 2", load_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (load_count !== '0) begin errors++; $display("[TB] FAIL async_count got %0d want 0", load_count); end
    checks++; if (core_rst !== 1'b1 || fetch_stall !== 1'b1 || ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_ctrl got %b%b%b want 111", core_rst, fetch_stall, ld_ready); end
    checks++; if (mem_we !== 1'b0 || dbg_ack !== 1'b0 || load_ovf !== 1'b0) begin errors++; $display("[TB] FAIL async_misc got %b%b%b want 000", mem_we, dbg_ack, load_ovf); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_last = (i == 3); ld_data = 32'hB1 + 32'(i);
      wr_q.push_back({ADDR_W'(i), 32'hB1 + 32'(i)});
      @(negedge clk);
      next_cycle();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    checks++; if (load_count !== 11'd4 || core_rst !== 1'b0) begin errors++; $display("[TB] FAIL reload_after_rst got count=%0d core_rst=%b want 4/0", load_count, core_rst); end
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0; reload = 1'b0;
    fetch_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
    ld_valid_s = 1'b0; ld_last_s = 1'b0; ld_data_s = '0; reload_s = 1'b0;
    fetch_addr_s = '0; dbg_req_s = 1'b0; dbg_addr_s = '0; mem_rdata_s = '0;
    test_reset();
    test_load_basic();
    test_overflow();
    test_toggle();
    test_dbg();
    test_back_to_back();
    test_reload_dbg();
    test_rst_midload();
    repeat (2) next_cycle();
    checks++; if (wr_q.size() != 0) begin errors++; $display("[TB] FAIL writes_pending got %0d want 0", wr_q.size()); end
    checks++; if (dbg_q.size() != 0) begin errors++; $display("[TB] FAIL dbg_pending got %0d want 0", dbg_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
